// File: rtl/mmu_port_arbiter_if.sv
// Bundle of the two L1 request ports, the MMU line port and arbiter status.
// slave is the arbiter's view; master is the surrounding caches and MMU.
interface mmu_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
);
  logic              immu_read;
  logic [ADDR_W-1:0] immu_addr;
  logic              immu_done;
  logic [LINE_W-1:0] immu_read_data;

  logic              dmmu_read;
  logic              dmmu_write;
  logic [ADDR_W-1:0] dmmu_addr;
  logic [LINE_W-1:0] dmmu_write_data;
  logic              dmmu_done;
  logic [LINE_W-1:0] dmmu_read_data;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_write_data;
  logic              mem_done;
  logic [LINE_W-1:0] mem_read_data;

  logic              busy;
  logic              grant_d;
  logic              err;

  modport slave (
    input  immu_read, immu_addr, dmmu_read, dmmu_write, dmmu_addr, dmmu_write_data,
           mem_done, mem_read_data,
    output immu_done, immu_read_data, dmmu_done, dmmu_read_data,
           mem_read, mem_write, mem_addr, mem_write_data, busy, grant_d, err
  );

  modport master (
    output immu_read, immu_addr, dmmu_read, dmmu_write, dmmu_addr, dmmu_write_data,
           mem_done, mem_read_data,
    input  immu_done, immu_read_data, dmmu_done, dmmu_read_data,
           mem_read, mem_write, mem_addr, mem_write_data, busy, grant_d, err
  );
endinterface

// File: rtl/mmu_port_arbiter.sv
// Round-robin arbiter sharing the MMU line port between the L1 I and D caches,
// with a watchdog that aborts hung memory transactions.
//   state  | meaning
//   IDLE   | no transaction, sampling requests
//   BUSY_I | I-side line read outstanding at MMU
//   BUSY_D | D-side read or write-back outstanding at MMU
//   RESP   | owner's done pulse is high this cycle
module mmu_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 256,
  parameter int TIMEOUT = 1024
) (
  input logic               sys_clk,
  input logic               rst,
  mmu_port_arbiter_if.slave bus
);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0]  WD_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(31);

  typedef enum logic [1:0] {S_IDLE, S_BUSY_I, S_BUSY_D, S_RESP} state_t;

  state_t            state_q, state_d;
  logic              last_owner_q, last_owner_d;
  logic              grant_d_q, grant_d_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              immu_done_q, immu_done_d;
  logic              dmmu_done_q, dmmu_done_d;
  logic [LINE_W-1:0] immu_rdata_q, immu_rdata_d;
  logic [LINE_W-1:0] dmmu_rdata_q, dmmu_rdata_d;
  logic [CNT_W-1:0]  wd_cnt_q, wd_cnt_d;

  logic i_req, d_req, pick_d, wd_fire;

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    grant_d_d    = grant_d_q;
    err_d        = err_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    immu_done_d  = 1'b0;
    dmmu_done_d  = 1'b0;
    immu_rdata_d = immu_rdata_q;
    dmmu_rdata_d = dmmu_rdata_q;
    wd_cnt_d     = wd_cnt_q;
    i_req        = bus.immu_read;
    d_req        = bus.dmmu_read | bus.dmmu_write;
    pick_d       = d_req & (~i_req | ~last_owner_q);
    // mem_done takes priority, so a completion on the timeout edge is not an error
    wd_fire      = (TIMEOUT != 0) && (wd_cnt_q == WD_LAST) && !bus.mem_done;

    unique case (state_q)
      S_IDLE: begin
        if (i_req || d_req) begin
          grant_d_d    = pick_d;
          last_owner_d = pick_d;
          wd_cnt_d     = '0;
          if (pick_d) begin
            mem_addr_d  = bus.dmmu_addr & LINE_MASK;
            mem_wdata_d = bus.dmmu_write_data;
            mem_write_d = bus.dmmu_write;
            mem_read_d  = ~bus.dmmu_write;
            state_d     = S_BUSY_D;
          end else begin
            mem_addr_d  = bus.immu_addr & LINE_MASK;
            mem_write_d = 1'b0;
            mem_read_d  = 1'b1;
            state_d     = S_BUSY_I;
          end
        end
      end
      S_BUSY_I, S_BUSY_D: begin
        wd_cnt_d = wd_cnt_q + 1'b1;
        if (bus.mem_done || wd_fire) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          err_d       = err_q | wd_fire;
          state_d     = S_RESP;
          if (state_q == S_BUSY_I) begin
            immu_done_d  = 1'b1;
            immu_rdata_d = wd_fire ? '0 : bus.mem_read_data;
          end else begin
            dmmu_done_d = 1'b1;
            if (wd_fire)          dmmu_rdata_d = '0;
            else if (!mem_write_q) dmmu_rdata_d = bus.mem_read_data;
          end
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_owner_q <= 1'b1;
      grant_d_q    <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      immu_done_q  <= 1'b0;
      dmmu_done_q  <= 1'b0;
      immu_rdata_q <= '0;
      dmmu_rdata_q <= '0;
      wd_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      grant_d_q    <= grant_d_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      immu_done_q  <= immu_done_d;
      dmmu_done_q  <= dmmu_done_d;
      immu_rdata_q <= immu_rdata_d;
      dmmu_rdata_q <= dmmu_rdata_d;
      wd_cnt_q     <= wd_cnt_d;
    end
  end

  assign bus.immu_done      = immu_done_q;
  assign bus.immu_read_data = immu_rdata_q;
  assign bus.dmmu_done      = dmmu_done_q;
  assign bus.dmmu_read_data = dmmu_rdata_q;
  assign bus.mem_read       = mem_read_q;
  assign bus.mem_write      = mem_write_q;
  assign bus.mem_addr       = mem_addr_q;
  assign bus.mem_write_data = mem_wdata_q;
  assign bus.busy           = busy_q;
  assign bus.grant_d        = grant_d_q;
  assign bus.err            = err_q;
endmodule

// File: doc/mmu_port_arbiter.md
Name: mmu_port_arbiter

Overview:
- Shares the single 256-bit line port of the MMU between the L1 instruction-cache refill path (read-only) and the L1 data-cache path (read and write-back).
- Sits between the two L1 caches and the MMU.
- Serialises requests, applies round-robin fairness, and returns each response with a one-cycle done pulse. Each L1 keeps its existing hold-until-done request protocol.
- Has a watchdog for hung memory transactions.

Parameters:
ADDR_W, 32, address width
LINE_W, 256, cache line width in bits
TIMEOUT, 1024, maximum cycles in a BUSY state before abort; 0 disables the watchdog

Ports:
sys_clk  in  1  system clock, all logic on posedge
rst  in  1  asynchronous, active-high reset
immu_read  in  1  I-side line read request, held until immu_done
immu_addr  in  ADDR_W  I-side line address
immu_done  out  1  one-cycle I-side completion pulse
immu_read_data  out  LINE_W  I-side returned line
dmmu_read  in  1  D-side line read request, held until dmmu_done
dmmu_write  in  1  D-side line write request, held until dmmu_done
dmmu_addr  in  ADDR_W  D-side line address
dmmu_write_data  in  LINE_W  D-side write line
dmmu_done  out  1  one-cycle D-side completion pulse
dmmu_read_data  out  LINE_W  D-side returned line
mem_read  out  1  read request to MMU, held until mem_done
mem_write  out  1  write request to MMU, held until mem_done
mem_addr  out  ADDR_W  line address to MMU, low 5 bits forced to 0
mem_write_data  out  LINE_W  write line to MMU
mem_done  in  1  MMU completion pulse
mem_read_data  in  LINE_W  MMU read line, valid while mem_done is high
busy  out  1  high in any state other than IDLE
grant_d  out  1  current or last owner: 0 = I, 1 = D
err  out  1  sticky watchdog-timeout flag

Behaviour:
- Reset (asynchronous, any state, including mid-transaction):
  - FSM goes to IDLE; last_owner is set to D so I-side wins the first tie.
  - All outputs go to 0, including the data registers and err.
  - Any outstanding MMU transaction is abandoned; a mem_done arriving afterwards in IDLE is ignored.
- All outputs are registered.
- FSM states: IDLE, BUSY_I, BUSY_D, RESP.
- IDLE, on each edge:
  - Only one side requesting: grant that side.
  - Both requesting: grant the side that is not last_owner.
  - Grant actions:
    - Latch addr with [4:0] cleared into mem_addr.
    - Latch write data for the D side.
    - Set mem_read or mem_write.
    - Set grant_d and last_owner.
    - Go to BUSY_x.
  - Latency: request seen at edge N gives mem_read/mem_write high from edge N.
- D-side read/write encoding:
  - dmmu_write and dmmu_read both high: treated as a write; the read is ignored.
  - Requests are sampled only in IDLE. Address or data changes during BUSY are ignored because they are latched.
- BUSY_x:
  - mem_read/mem_write, mem_addr and mem_write_data are held stable.
  - On mem_done:
    - Capture mem_read_data into the owner's read_data register (D-side writes capture nothing; data is unchanged).
    - Clear mem_read/mem_write.
    - Assert the owner's done.
    - Go to RESP.
  - The non-owner's done and read_data do not change.
- RESP:
  - Owner's done is high for exactly this one cycle.
  - Unconditional transition to IDLE on the next edge.
  - The requester must deassert its request at the edge where it samples done high, so IDLE never re-grants a completed request.
- Minimum service turnaround: 3 cycles (grant, mem_done, RESP).
- Back-to-back alternation: two sides continuously requesting are served I, D, I, D...
- Read data is held until the next completion for the same side.
- Watchdog:
  - A counter clears on entry to BUSY and increments each BUSY cycle.
  - If it reaches TIMEOUT with no mem_done:
    - Clear the mem request.
    - Zero the owner's read_data.
    - Set err (sticky; cleared only by rst).
    - Pulse the owner's done via RESP.
  - The counter width is clog2(TIMEOUT+1). When TIMEOUT = 0 the counter is unused and never fires.
- mem_done in IDLE or RESP is ignored.
- mem_done exactly on the timeout cycle: treated as a normal completion; err is not set.

Test Plan:
- Single I read:
  - Stimulus: immu_read=1, immu_addr=0x0000_1234; MMU returns mem_done 4 cycles after the request with data 0xA5..A5.
  - Response: mem_addr=0x0000_1220 and mem_read=1 on the grant edge; immu_done is a 1-cycle pulse; immu_read_data=0xA5..A5; dmmu_done stays 0.
- Simultaneous requests after reset:
  - Stimulus: immu_read and dmmu_read asserted in the same cycle.
  - Response: I-side served first, then D-side; grant_d reads 0 then 1; done pulses never overlap.
- Sustained contention:
  - Stimulus: both sides re-request immediately after each done, for 6 transactions.
  - Response: grant order I, D, I, D, I, D.
- D-side write with both bits high:
  - Stimulus: dmmu_write=1, dmmu_read=1, dmmu_write_data=0x1122..; then change dmmu_write_data mid-BUSY.
  - Response: mem_write=1, mem_read=0, mem_write_data stays 0x1122..; dmmu_read_data unchanged after done.
- Watchdog abort:
  - Stimulus: TIMEOUT=8; MMU never asserts mem_done.
  - Response: after 8 BUSY cycles mem_read drops, immu_done pulses, immu_read_data=0, err=1 and stays 1.
- Reset mid-transaction:
  - Stimulus: rst pulsed during BUSY_D; stale mem_done arrives 2 cycles later.
  - Response: all outputs 0 immediately; stale mem_done is ignored (no done pulse); the next simultaneous request goes to the I side.
